bcd_modn_counter: RTL and testbench



---
 rtl/bcd_modn_counter.sv | 124 ++++++++++++
 tb/tb_bcd_modn_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_modn_counter.sv
// Multi-digit BCD modulo-N counter with up/down direction, synchronous clear,
// validated parallel load, a sticky load-error flag and a combinational
// terminal-count strobe (CARRY) for zero-latency cascading via EN.
module bcd_modn_counter #(
    parameter int DIGITS    = 2,
    parameter int MODULUS   = 60,
    parameter int RESET_VAL = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    input  logic                LOAD,
    input  logic [4*DIGITS-1:0] LOAD_VAL,
    input  logic                EN,
    input  logic                UP,
    output logic [4*DIGITS-1:0] NUM,
    output logic                CARRY,
    output logic                ERR
);

    localparam int W = 4 * DIGITS;

    // Elaboration-time decimal to packed-BCD conversion for the constants.
    function automatic logic [W-1:0] to_bcd(input int value);
        int v;
        v      = value;
        to_bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            to_bcd[4*i +: 4] = 4'(v % 10);
            v                = v / 10;
        end
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);
    localparam logic [W-1:0] RST_BCD = to_bcd(RESET_VAL);

    logic [W-1:0] num_q, num_d;
    logic         err_q, err_d;
    logic [W-1:0] num_inc, num_dec;
    logic         inc_c, dec_b;
    logic         nib_ok;
    logic         load_ok;
    logic         at_max, at_zero;

    // Ripple BCD increment/decrement of the current count and nibble check of LOAD_VAL.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // through the block can leave one unassigned and infer a latch.
        num_inc = num_q;
        num_dec = num_q;
        inc_c   = 1'b1;
        dec_b   = 1'b1;
        nib_ok  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (inc_c) begin
                if (num_q[4*i +: 4] == 4'd9) begin
                    num_inc[4*i +: 4] = 4'd0;
                end else begin
                    num_inc[4*i +: 4] = num_q[4*i +: 4] + 4'd1;
                    inc_c             = 1'b0;
                end
            end
            if (dec_b) begin
                if (num_q[4*i +: 4] == 4'd0) begin
                    num_dec[4*i +: 4] = 4'd9;
                end else begin
                    num_dec[4*i +: 4] = num_q[4*i +: 4] - 4'd1;
                    dec_b             = 1'b0;
                end
            end
            if (LOAD_VAL[4*i +: 4] > 4'd9) begin
                nib_ok = 1'b0;
            end
        end
    end

    // With all nibbles <= 9, packed-BCD ordering equals decimal ordering,
    // so the range check is a plain vector compare against MODULUS-1.
    assign load_ok = nib_ok && (LOAD_VAL <= MAX_BCD);
    assign at_max  = (num_q == MAX_BCD);
    assign at_zero = (num_q == '0);

    // Terminal-count strobe: high exactly in the cycle whose edge wraps the count.
    assign CARRY = EN & ~LOAD & ~CLR & ~RST & (UP ? at_max : at_zero);

    // Next-state selection with priority CLR > LOAD > EN.
    always_comb begin
        num_d = num_q;
        err_d = err_q;
        if (CLR) begin
            num_d = '0;
            err_d = 1'b0;
        end else if (LOAD) begin
            if (load_ok) begin
                num_d = LOAD_VAL;
            end else begin
                err_d = 1'b1;
            end
        end else if (EN) begin
            if (UP) begin
                num_d = at_max ? '0 : num_inc;
            end else begin
                num_d = at_zero ? MAX_BCD : num_dec;
            end
        end
    end

    // Count and error registers with asynchronous reset to RESET_VAL / clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            num_q <= RST_BCD;
            err_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop
            // samples the pre-edge values, independent of statement order.
            num_q <= num_d;
            err_q <= err_d;
        end
    end

    assign NUM = num_q;
    assign ERR = err_q;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// Scoreboard bench for bcd_modn_counter: stimulus pushes the expected
// per-cycle response, a negedge monitor pops and compares it.
module tb_bcd_modn_counter;

    typedef struct {
        int         which;   // 0 = main counter, 1 = cascade pair
        logic [7:0] num;
        logic [7:0] num2;
        logic       carry;
        logic       err;
        string      name;
    } exp_t;

    logic       clk, rst, clr, load, en, up, casc_en;
    logic [7:0] lv;
    logic [7:0] num, sec_num, hr_num;
    logic       carry, err, sec_carry, sec_err, hr_carry, hr_err;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   inv_viol = 0;

    bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .RESET_VAL(15)) dut (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD(load), .LOAD_VAL(lv),
        .EN(en), .UP(up), .NUM(num), .CARRY(carry), .ERR(err)
    );

    bcd_modn_counter #(.DIGITS(2), .MODULUS(60), .RESET_VAL(0)) u_sec (
        .CLK(clk), .RST(rst), .CLR(1'b0), .LOAD(1'b0), .LOAD_VAL(8'h00),
        .EN(casc_en), .UP(1'b1), .NUM(sec_num), .CARRY(sec_carry), .ERR(sec_err)
    );

    bcd_modn_counter #(.DIGITS(2), .MODULUS(24), .RESET_VAL(0)) u_hr (
        .CLK(clk), .RST(rst), .CLR(1'b0), .LOAD(1'b0), .LOAD_VAL(8'h00),
        .EN(sec_carry), .UP(1'b1), .NUM(hr_num), .CARRY(hr_carry), .ERR(hr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int w, input logic [7:0] xn, input logic [7:0] xn2,
                        input logic xc, input logic xe, input string nm);
        exp_t e;
        e.which = w; e.num = xn; e.num2 = xn2; e.carry = xc; e.err = xe; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs and record what the DUT must show during it.
    task automatic step(input logic c, input logic l, input logic [7:0] v,
                        input logic e, input logic u, input logic [7:0] xn,
                        input logic xc, input logic xe, input string nm);
        clr = c; load = l; lv = v; en = e; up = u;
        push(0, xn, 8'h00, xc, xe, nm);
        tick();
    endtask

    // Monitor: compare the DUT against the oldest expectation each cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.which == 0) begin
                check({e.name, ".num"},   32'(num),   32'(e.num));
                check({e.name, ".carry"}, 32'(carry), 32'(e.carry));
                check({e.name, ".err"},   32'(err),   32'(e.err));
            end else begin
                check({e.name, ".sec"},      32'(sec_num),   32'(e.num));
                check({e.name, ".hr"},       32'(hr_num),    32'(e.num2));
                check({e.name, ".sec_carry"}, 32'(sec_carry), 32'(e.carry));
                check({e.name, ".hr_carry"},  32'(hr_carry),
                      32'(e.carry && (e.num2 == 8'h23)));
                check({e.name, ".errs"}, 32'({sec_err, hr_err}), 32'(0));
            end
        end
    end

    // Invariant: every nibble is BCD and the value is below the modulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (num[3:0] > 4'd9 || num[7:4] > 4'd5) inv_viol++;
            if (sec_num[3:0] > 4'd9 || sec_num[7:4] > 4'd5) inv_viol++;
            if (hr_num[3:0] > 4'd9 || hr_num[7:4] > 4'd2 ||
                (hr_num[7:4] == 4'd2 && hr_num[3:0] > 4'd3)) inv_viol++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         m;
        logic       merr;
        logic       rc, rl, re, ru, rv, rcarry;
        logic [7:0] rlv;
        int         lval;

        rst = 1'b1; clr = 1'b0; load = 1'b0; lv = 8'h00;
        en = 1'b0; up = 1'b1; casc_en = 1'b0;
        tick();

        // Reset holds 0x15 and masks CARRY even with EN high.
        step(0, 0, 8'h00, 1, 1, 8'h15, 0, 0, "in_reset");
        rst = 1'b0;

        // Up-count 50 edges from 15: wrap 59 -> 00, end at 05.
        for (int k = 0; k < 50; k++) begin
            step(0, 0, 8'h00, 1, 1, bcd2((15 + k) % 60), ((15 + k) % 60) == 59, 0, "count_up");
        end
        step(0, 0, 8'h00, 0, 1, 8'h05, 0, 0, "up_end");

        // Down-count from a loaded 01.
        step(0, 1, 8'h01, 0, 0, 8'h05, 0, 0, "load_01");
        step(0, 0, 8'h00, 1, 0, 8'h01, 0, 0, "dn_01");
        step(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, "dn_00");
        step(0, 0, 8'h00, 1, 0, 8'h59, 0, 0, "dn_59");
        step(0, 0, 8'h00, 0, 0, 8'h58, 0, 0, "dn_58");

        // Load validation and sticky ERR.
        step(0, 1, 8'h3A, 0, 0, 8'h58, 0, 0, "load_3A");
        step(0, 1, 8'h72, 0, 0, 8'h58, 0, 1, "load_72");
        step(0, 1, 8'h42, 0, 0, 8'h58, 0, 1, "load_42");
        step(1, 0, 8'h00, 0, 0, 8'h42, 0, 1, "clr");
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "after_clr");

        // CLR beats an invalid LOAD and leaves ERR at 0.
        step(0, 1, 8'h99, 0, 0, 8'h00, 0, 0, "load_99");
        step(1, 1, 8'h99, 0, 0, 8'h00, 0, 1, "clr_load_bad");
        step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, "clr_wins");

        // LOAD beats EN at the terminal value; CLR beats LOAD.
        step(0, 1, 8'h59, 0, 1, 8'h00, 0, 0, "load_59");
        step(0, 1, 8'h30, 1, 1, 8'h59, 0, 0, "load_vs_en");
        step(1, 1, 8'h45, 1, 1, 8'h30, 0, 0, "clr_vs_load");
        step(0, 0, 8'h00, 0, 1, 8'h00, 0, 0, "clr_prio");

        // CLR masks CARRY; direction change takes effect immediately.
        step(1, 0, 8'h00, 1, 0, 8'h00, 0, 0, "clr_mask");
        step(0, 0, 8'h00, 1, 0, 8'h00, 1, 0, "dn_wrap");
        step(0, 0, 8'h00, 1, 1, 8'h59, 1, 0, "up_wrap");
        step(0, 1, 8'h37, 0, 1, 8'h00, 0, 0, "load_37");
        step(0, 0, 8'h00, 1, 1, 8'h37, 0, 0, "at_37");

        // Asynchronous reset between edges while counting from 0x38.
        step(0, 0, 8'h00, 0, 1, 8'h38, 0, 0, "pre_rst");
        clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
        #1;
        rst = 1'b1;
        push(0, 8'h15, 8'h00, 0, 0, "async_rst");
        tick();
        rst = 1'b0;
        step(0, 0, 8'h00, 0, 1, 8'h15, 0, 0, "after_rst");

        // Random EN/UP/LOAD/CLR run against a decimal reference model.
        m = 15; merr = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            rc = ($urandom_range(31) == 0);
            rl = ($urandom_range(7) == 0);
            re = ($urandom_range(3) != 0);
            ru = 1'($urandom_range(1));
            rlv = ($urandom_range(1) == 0) ? bcd2($urandom_range(59)) : 8'($urandom);
            lval = int'(rlv[7:4]) * 10 + int'(rlv[3:0]);
            rv = (rlv[7:4] <= 4'd9) && (rlv[3:0] <= 4'd9) && (lval < 60);
            rcarry = re && !rl && !rc && (ru ? (m == 59) : (m == 0));
            step(rc, rl, rlv, re, ru, bcd2(m), rcarry, merr, "rand");
            if (rc) begin
                m = 0; merr = 1'b0;
            end else if (rl) begin
                if (rv) m = lval;
                else    merr = 1'b1;
            end else if (re) begin
                if (ru) m = (m == 59) ? 0 : m + 1;
                else    m = (m == 0) ? 59 : m - 1;
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;

        // Cascade: mod-60 CARRY drives a mod-24 stage for a full day.
        casc_en = 1'b1;
        for (int k = 0; k < 1440; k++) begin
            push(1, bcd2(k % 60), bcd2((k / 60) % 24), (k % 60) == 59, 0, "cascade");
            tick();
        end
        casc_en = 1'b0;
        push(1, 8'h00, 8'h00, 0, 0, "cascade_end");
        tick();

        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'(0));
        check("invariant", 32'(inv_viol), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
